// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV core.
//   Produces the stage-register enables, IF/ID and ID/EX flushes and an EX/MEM
//   bubble. It resolves load-use hazards, branch/jump mispredicts, multi-cycle
//   EX operations and data-memory wait states.
//   Inputs:  ID/EX register-use info, EX load/mispredict/multi-cycle status,
//            MEM request/ready handshake.
//   Outputs: PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
//            IF_ID_flush, ID_EX_flush, EX_MEM_bubble, stall_cnt, flush_cnt.
//   Optional macro HAZARD_CTRL_PERF_CNT_EN builds saturating stall/flush
//   counters; without it both counter ports are tied to 0.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [2:0]       ID_ValidReg,
  input  logic [4:0]       EX_rd,
  input  logic [2:0]       EX_ValidReg,
  input  logic             EX_MemRead,
  input  logic             EX_mispredict,
  input  logic             EX_mc_start,
  input  logic             EX_mc_done,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {INIT, RUN, EX_WAIT} state_t;
  state_t state_q, state_d;
  logic mem_stall, load_use;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  always_comb begin
    mem_stall = MEM_req & ~MEM_ready;
    load_use  = EX_MemRead & EX_ValidReg[0] & (EX_rd != 5'd0) &
                ((ID_ValidReg[1] & (ID_rs1 == EX_rd)) | (ID_ValidReg[2] & (ID_rs2 == EX_rd)));
    state_d       = state_q;
    {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = 5'b11111;
    {IF_ID_flush, ID_EX_flush, EX_MEM_bubble}        = 3'b000;
    if (state_q == INIT) begin
      {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = 5'b00000;
      {IF_ID_flush, ID_EX_flush, EX_MEM_bubble}        = 3'b111;
      state_d = RUN;
    end else if (mem_stall) begin
      // Whole-pipe freeze; EX keeps its instruction so its events re-present.
      {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = 5'b00000;
    end else if (state_q == EX_WAIT) begin
      // Mispredicts are ignored here; EX raises them again after completion.
      if (EX_mc_done) state_d = RUN;
      else begin
        {PC_en, IF_ID_en, ID_EX_en} = 3'b000;
        EX_MEM_bubble = 1'b1;
      end
    end else if (EX_mispredict) begin
      // Squashing ID also discards any coincident load-use hazard.
      {IF_ID_flush, ID_EX_flush} = 2'b11;
    end else if (EX_mc_start & ~EX_mc_done) begin
      {PC_en, IF_ID_en, ID_EX_en} = 3'b000;
      EX_MEM_bubble = 1'b1;
      state_d = EX_WAIT;
    end else if (load_use) begin
      // One bubble lets the load reach MEM/WB for forwarding.
      {PC_en, IF_ID_en} = 2'b00;
      ID_EX_flush = 1'b1;
    end
  end
`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // IF_ID_flush with PC_en high only occurs for an accepted mispredict.
  always_comb begin
    stall_cnt_d = (state_q != INIT && !PC_en && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (IF_ID_flush && PC_en && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with directed vectors.
module tb_hazard_ctrl;
  localparam int CNT_W = 32;
  localparam logic [7:0] INIT_O = 8'b00000_111;
  localparam logic [7:0] RUN_O  = 8'b11111_000;
  localparam logic [7:0] MEMS_O = 8'b00000_000;
  localparam logic [7:0] MISP_O = 8'b11111_110;
  localparam logic [7:0] MC_O   = 8'b00011_001;
  localparam logic [7:0] LU_O   = 8'b00111_010;
  typedef struct {
    logic [7:0]       e;
    int               tag;
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] f;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic [2:0] ID_ValidReg, EX_ValidReg;
  logic EX_MemRead, EX_mispredict, EX_mc_start, EX_mc_done, MEM_req, MEM_ready;
  logic PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, EX_MEM_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] outs;
  exp_t q[$];
  logic [CNT_W-1:0] exp_s = '0, exp_f = '0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg),
    .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_MemRead(EX_MemRead),
    .EX_mispredict(EX_mispredict), .EX_mc_start(EX_mc_start), .EX_mc_done(EX_mc_done),
    .MEM_req(MEM_req), .MEM_ready(MEM_ready), .PC_en(PC_en), .IF_ID_en(IF_ID_en),
    .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_bubble(EX_MEM_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  assign outs = {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, EX_MEM_bubble};
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_chk++;
      if (outs !== x.e) begin
        n_fail++;
        $display("FAIL outs tag %0d: got %b want %b", x.tag, outs, x.e);
      end
      n_chk++;
      if (stall_cnt !== x.s || flush_cnt !== x.f) begin
        n_fail++;
        $display("FAIL counters tag %0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 x.tag, stall_cnt, flush_cnt, x.s, x.f);
      end
    end
  task automatic chk(input logic [7:0] e, input int tag);
    if (!rst_n) begin
      exp_s = '0;
      exp_f = '0;
    end
    q.push_back('{e, tag, exp_s, exp_f});
`ifdef HAZARD_CTRL_PERF_CNT_EN
    if (rst_n && e[7] == 1'b0 && e != INIT_O) exp_s = exp_s + 1;
    if (rst_n && e == MISP_O) exp_f = exp_f + 1;
`endif
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {ID_rs1, ID_rs2, EX_rd, ID_ValidReg, EX_ValidReg} = '0;
    {EX_MemRead, EX_mispredict, EX_mc_start, EX_mc_done, MEM_req, MEM_ready} = '0;
  endtask
  initial begin
    idle();
    @(posedge clk);
    #1;
    chk(INIT_O, 0);
    chk(INIT_O, 1);
    rst_n = 1'b1;
    chk(INIT_O, 2);
    chk(RUN_O, 3);
    EX_MemRead = 1; EX_rd = 5; EX_ValidReg = 3'b001; ID_rs1 = 5; ID_ValidReg = 3'b010;
    chk(LU_O, 4);
    EX_MemRead = 0;
    chk(RUN_O, 5);
    EX_MemRead = 1; EX_rd = 0; ID_rs1 = 0;
    chk(RUN_O, 6);
    EX_rd = 7; ID_rs1 = 3; ID_rs2 = 7; ID_ValidReg = 3'b100;
    chk(LU_O, 7);
    ID_ValidReg = 3'b010;
    chk(RUN_O, 8);
    ID_ValidReg = 3'b100; EX_mispredict = 1;
    chk(MISP_O, 9);
    idle();
    EX_mc_start = 1;
    chk(MC_O, 10);
    EX_mc_start = 0; EX_mispredict = 1;
    chk(MC_O, 11);
    EX_mispredict = 0;
    chk(MC_O, 12);
    chk(MC_O, 13);
    EX_mc_done = 1;
    chk(RUN_O, 14);
    EX_mc_done = 0;
    chk(RUN_O, 15);
    EX_mc_start = 1; EX_mc_done = 1;
    chk(RUN_O, 16);
    EX_mc_done = 0;
    chk(MC_O, 17);
    EX_mc_start = 0; MEM_req = 1; EX_mispredict = 1;
    chk(MEMS_O, 18);
    EX_mc_done = 1;
    chk(MEMS_O, 19);
    EX_mc_done = 0;
    chk(MEMS_O, 20);
    MEM_req = 0;
    chk(MC_O, 21);
    EX_mc_done = 1;
    chk(RUN_O, 22);
    EX_mc_done = 0; EX_mispredict = 0; MEM_req = 1; MEM_ready = 1;
    chk(RUN_O, 23);
    MEM_ready = 0; EX_mispredict = 1;
    chk(MEMS_O, 24);
    MEM_ready = 1;
    chk(MISP_O, 25);
    EX_mc_start = 1;
    chk(MISP_O, 26);
    idle();
    EX_mc_start = 1;
    chk(MC_O, 27);
    EX_mc_start = 0;
    chk(MC_O, 28);
    rst_n = 0;
    chk(INIT_O, 29);
    rst_n = 1;
    chk(INIT_O, 30);
    chk(RUN_O, 31);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
